// File: rtl/regulated_scheduler.sv
// Queue scheduler with round-robin, fixed-priority, budget-regulated fixed-priority and TDMA modes.
// The grant is registered and held until consumed; the mode only changes between grants.
module regulated_scheduler #(
  parameter int  NUMBER_OF_QUEUES = 4,
  parameter int  REGISTER_SIZE    = 32,
  parameter int  PRIORITY_SIZE    = 4,
  localparam int N                = NUMBER_OF_QUEUES,
  localparam int ID_W             = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic [N*PRIORITY_SIZE-1:0] priorities,
  input  logic [N*REGISTER_SIZE-1:0] budgets,
  input  logic [REGISTER_SIZE-1:0]   period,
  input  logic [REGISTER_SIZE-1:0]   slot_length,
  input  logic                       restart,
  input  logic [N-1:0]               empty,
  output logic [ID_W-1:0]            id,
  output logic                       valid,
  input  logic                       ready,
  output logic [N-1:0]               budget_exhausted,
  output logic                       replenish
);

  typedef enum logic [1:0] {
    MODE_RR   = 2'd0,
    MODE_FP   = 2'd1,
    MODE_BFP  = 2'd2,
    MODE_TDMA = 2'd3
  } mode_t;

  typedef logic [REGISTER_SIZE-1:0] cnt_t;

  typedef struct packed {
    logic            hit;
    logic [ID_W-1:0] idx;
  } pick_t;

  localparam cnt_t            ONE      = cnt_t'(1);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N - 1);
  localparam logic [ID_W-1:0] ID_ONE   = ID_W'(1);

  mode_t           active_mode, sel_mode;
  logic [ID_W-1:0] rr_ptr, rr_ptr_next, slot, slot_next;
  cnt_t            period_cnt, period_cnt_next, slot_cnt, slot_cnt_next, slot_len;
  cnt_t            budget_left [N];
  cnt_t            budget_next [N];
  logic            hs, free, wrap, slot_end;
  logic [N-1:0]    eligible;
  pick_t           pick;

  function automatic pick_t rr_pick(input logic [N-1:0] elig, input logic [ID_W-1:0] ptr);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!p.hit && elig[idx]) begin
        p.hit = 1'b1;
        p.idx = ID_W'(idx);
      end
    end
    return p;
  endfunction

  // Strict '>' keeps the lowest index on equal priorities.
  function automatic pick_t fp_pick(input logic [N-1:0] elig, input logic [N*PRIORITY_SIZE-1:0] prio);
    pick_t                    p;
    logic [PRIORITY_SIZE-1:0] best, cur;
    p    = '0;
    best = '0;
    for (int i = 0; i < N; i++) begin
      cur = prio[i*PRIORITY_SIZE +: PRIORITY_SIZE];
      if (elig[i] && (!p.hit || cur > best)) begin
        p.hit = 1'b1;
        p.idx = ID_W'(i);
        best  = cur;
      end
    end
    return p;
  endfunction

  // Selection looks at next-cycle pointer, budgets and slot, so a newly offered grant
  // always agrees with the state that is visible alongside it.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch can be inferred.
    hs              = valid & ready;
    free            = ~valid | ready;
    sel_mode        = free ? mode_t'(mode) : active_mode;
    wrap            = (period != '0) && (period_cnt == period - ONE);
    slot_len        = (slot_length == '0) ? ONE : slot_length;
    slot_end        = (slot_cnt == slot_len - ONE);
    period_cnt_next = period_cnt + ONE;
    slot_cnt_next   = slot_cnt + ONE;
    slot_next       = slot;
    rr_ptr_next     = hs ? id : rr_ptr;
    pick            = '0;

    if (restart || (period == '0) || wrap) period_cnt_next = '0;

    if (restart) begin
      slot_cnt_next = '0;
      slot_next     = '0;
    end else if (slot_end) begin
      slot_cnt_next = '0;
      slot_next     = (slot == LAST_ID) ? '0 : slot + ID_ONE;
    end

    // Reload beats decrement: a grant consumed on the reload cycle costs nothing.
    for (int i = 0; i < N; i++) begin
      budget_next[i] = budget_left[i];
      if (restart || wrap)
        budget_next[i] = budgets[i*REGISTER_SIZE +: REGISTER_SIZE];
      else if (hs && active_mode == MODE_BFP && id == ID_W'(i) && budget_left[i] != '0)
        budget_next[i] = budget_left[i] - ONE;
    end

    for (int i = 0; i < N; i++) begin
      eligible[i] = ~empty[i]
                  & ((sel_mode != MODE_BFP)  | (budget_next[i] != '0))
                  & ((sel_mode != MODE_TDMA) | (slot_next == ID_W'(i)));
    end

    case (sel_mode)
      MODE_RR:   pick = rr_pick(eligible, rr_ptr_next);
      MODE_TDMA: begin
        pick.hit = |eligible;
        pick.idx = slot_next;
      end
      default:   pick = fp_pick(eligible, priorities);
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) budget_exhausted[i] = (budget_left[i] == '0);
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid       <= 1'b0;
      id          <= '0;
      active_mode <= MODE_RR;
      rr_ptr      <= LAST_ID;
      period_cnt  <= '0;
      slot        <= '0;
      slot_cnt    <= '0;
      replenish   <= 1'b0;
      // NOTE: the budget array is a handful of flops, so it is reset by loading the live budgets.
      for (int i = 0; i < N; i++) budget_left[i] <= budgets[i*REGISTER_SIZE +: REGISTER_SIZE];
    end else begin
      if (free) begin
        active_mode <= sel_mode;
        valid       <= pick.hit;
        id          <= pick.idx;
      end
      rr_ptr     <= rr_ptr_next;
      period_cnt <= period_cnt_next;
      slot       <= slot_next;
      slot_cnt   <= slot_cnt_next;
      replenish  <= wrap & ~restart;
      for (int i = 0; i < N; i++) budget_left[i] <= budget_next[i];
    end
  end

endmodule
